multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter ALUOP_W, default 6: width of ALUOp; funct is zero-extended when ALUOP_W > 6.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15: maximum consecutive MemReady-low cycles tolerated in a memory state.
REQ-003 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-004 SHALL have the following ports (name  direction  width  meaning):
  Clk  in  1  sole clock, rising edge.
  Rst  in  1  synchronous reset, active-low.
  Instruction  in  32  IR contents; opcode [31:26], funct [5:0].
  Zero  in  1  ALU zero flag.
  MemReady  in  1  memory access complete this cycle.
  PCWrite, IRWrite, IorD, RegDst, MemtoReg, RegWrite, MemRead, MemWrite, ALUSrcA  out  1 each  datapath controls.
  ALUSrcB  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
  PCSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target.
  ALUOp  out  ALUOP_W  ALU function code.
  State  out  4  current state encoding (debug).
  Fault  out  1  sticky error flag.
  InstrCount  out  CNT_W  retired-instruction count.

Function
REQ-005 SHALL be a Moore FSM; outputs decode from the registered state, except PCWrite in BRANCH (=Zero) and IRWrite/PCWrite in FETCH (=MemReady).
REQ-006 SHALL use state encoding FETCH=0, DECODE=1, EXEC_R=2, MEMADDR=3, MEM_RD=4, MEM_WR=5, WB_R=6, WB_LD=7, BRANCH=8, JUMP=9, FAULT=10.
REQ-007 SHALL deassert every 1-bit control and drive 0 on ALUSrcB, PCSrc and ALUOp in any state that does not list them below.
REQ-008 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=0x20, PCSrc=00, IRWrite=PCWrite=MemReady; go to DECODE when MemReady=1, else stay.
REQ-009 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=0x20; route opcode 000000->EXEC_R, 100011 or 101011->MEMADDR, 000100->BRANCH, 000010->JUMP, any other->FAULT.
REQ-010 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=funct; next state WB_R.
REQ-011 WB_R: RegDst=1, MemtoReg=0, RegWrite=1; next state FETCH.
REQ-012 MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=0x20; next state MEM_RD for lw, MEM_WR for sw.
REQ-013 MEM_RD: MemRead=1, IorD=1; go to WB_LD when MemReady=1, else stay.
REQ-014 WB_LD: RegDst=0, MemtoReg=1, RegWrite=1; next state FETCH.
REQ-015 MEM_WR: MemWrite=1, IorD=1; go to FETCH when MemReady=1, else stay.
REQ-016 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=0x22, PCSrc=01, PCWrite=Zero; next state FETCH.
REQ-017 JUMP: PCSrc=10, PCWrite=1; next state FETCH.
REQ-018 FAULT: Fault=1, all enables 0; SHALL remain in FAULT until reset regardless of other inputs.
REQ-019 Wait counter: in FETCH, MEM_RD and MEM_WR, SHALL increment on each MemReady=0 cycle and clear on MemReady=1 or on state change.
REQ-020 Timeout: with MemReady=0 and counter==MEM_TIMEOUT, next state SHALL be FAULT (MEM_TIMEOUT+1 consecutive not-ready cycles); MemReady=1 on that same cycle SHALL take the normal transition.
REQ-021 InstrCount SHALL increment by 1 on each transition into FETCH from WB_R, WB_LD, MEM_WR, BRANCH or JUMP, wrapping modulo 2^CNT_W; a branch counts whether taken or not.

Reset
REQ-022 On a rising Clk edge with Rst=0: State<=FETCH, wait counter<=0, InstrCount<=0, Fault<=0.
REQ-023 While Rst=0, PCWrite, IRWrite, RegWrite, MemRead and MemWrite SHALL be forced to 0 combinationally in the same cycle, including mid-operation.
REQ-024 The first cycle after Rst returns to 1 SHALL be FETCH with the FETCH outputs.

Verification
REQ-025 R-type: Instruction=0x012A4020, MemReady=1 -> FETCH,DECODE,EXEC_R(ALUOp=0x20),WB_R(RegWrite=1,RegDst=1),FETCH; InstrCount 0->1.
REQ-026 lw 0x8D280004, MemReady=0 for 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then WB_LD (MemtoReg=1, RegWrite=1), then FETCH.
REQ-027 beq 0x11090003: with Zero=1 -> BRANCH PCWrite=1, PCSrc=01; with Zero=0 -> PCWrite=0; InstrCount increments in both cases.
REQ-028 Opcode 0x3F -> DECODE then FAULT, Fault=1; FAULT held for 20 cycles of arbitrary inputs; Rst=0 -> FETCH, Fault=0.
REQ-029 MemReady=0 in FETCH for 16 cycles (MEM_TIMEOUT=15) -> FAULT on the 17th; MemReady=1 on the 16th cycle -> DECODE instead.
REQ-030 Rst=0 during MEM_WR -> MemWrite=0 in the same cycle; next edge State=FETCH, InstrCount=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control unit: Moore FSM with memory-wait timeout,
// sticky fault state and a retired-instruction counter.
module multicycle_controller #(
   parameter int ALUOP_W     = 6,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic [31:0]        Instruction,
   input  logic               Zero,
   input  logic               MemReady,
   output logic               PCWrite,
   output logic               IRWrite,
   output logic               IorD,
   output logic               RegDst,
   output logic               MemtoReg,
   output logic               RegWrite,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSrc,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [3:0]         State,
   output logic               Fault,
   output logic [CNT_W-1:0]   InstrCount
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      EXEC_R  = 4'd2,
      MEMADDR = 4'd3,
      MEM_RD  = 4'd4,
      MEM_WR  = 4'd5,
      WB_R    = 4'd6,
      WB_LD   = 4'd7,
      BRANCH  = 4'd8,
      JUMP    = 4'd9,
      FAULT   = 4'd10
   } state_t;

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1) + 1;
   localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
   localparam logic [ALUOP_W-1:0] ALU_ADD    = ALUOP_W'(6'h20);
   localparam logic [ALUOP_W-1:0] ALU_SUB    = ALUOP_W'(6'h22);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t              state_r;
   state_t              next_state_s;
   logic [WAIT_W-1:0]   wait_cnt_r;
   logic [CNT_W-1:0]    instr_cnt_r;
   logic                is_wait_s;
   logic                retire_s;
   logic                pc_write_s;
   logic                ir_write_s;
   logic                reg_write_s;
   logic                mem_read_s;
   logic                mem_write_s;
   logic [5:0]          opcode_s;
   logic [5:0]          funct_s;
   logic                unused_instr_bits;

   assign opcode_s          = Instruction[31:26];
   assign funct_s           = Instruction[5:0];
   assign unused_instr_bits = ^Instruction[25:6];
   assign is_wait_s = (state_r == FETCH) || (state_r == MEM_RD) || (state_r == MEM_WR);
   assign retire_s  = (next_state_s == FETCH) &&
                      ((state_r == WB_R) || (state_r == WB_LD) || (state_r == MEM_WR) ||
                       (state_r == BRANCH) || (state_r == JUMP));

   // Next-state selection; a stalled memory state falls into FAULT once the wait budget is spent.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         FETCH: begin
            if (MemReady) next_state_s = DECODE;
            else if (wait_cnt_r == WAIT_LIMIT) next_state_s = FAULT;
            else next_state_s = FETCH;
         end
         DECODE: begin
            case (opcode_s)
               OP_RTYPE:     next_state_s = EXEC_R;
               OP_LW, OP_SW: next_state_s = MEMADDR;
               OP_BEQ:       next_state_s = BRANCH;
               OP_J:         next_state_s = JUMP;
               default:      next_state_s = FAULT;
            endcase
         end
         EXEC_R:  next_state_s = WB_R;
         WB_R:    next_state_s = FETCH;
         MEMADDR: begin
            if (opcode_s == OP_LW) next_state_s = MEM_RD;
            else if (opcode_s == OP_SW) next_state_s = MEM_WR;
            else next_state_s = FAULT;
         end
         MEM_RD: begin
            if (MemReady) next_state_s = WB_LD;
            else if (wait_cnt_r == WAIT_LIMIT) next_state_s = FAULT;
            else next_state_s = MEM_RD;
         end
         MEM_WR: begin
            if (MemReady) next_state_s = FETCH;
            else if (wait_cnt_r == WAIT_LIMIT) next_state_s = FAULT;
            else next_state_s = MEM_WR;
         end
         WB_LD:   next_state_s = FETCH;
         BRANCH:  next_state_s = FETCH;
         JUMP:    next_state_s = FETCH;
         FAULT:   next_state_s = FAULT;
         default: next_state_s = FAULT;
      endcase
   end

   // State, wait counter and retired-instruction counter.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_r     <= FETCH;
         wait_cnt_r  <= '0;
         instr_cnt_r <= '0;
      end else begin
         state_r <= next_state_s;
         if (is_wait_s && !MemReady && (next_state_s == state_r))
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
         else
            wait_cnt_r <= '0;
         if (retire_s)
            instr_cnt_r <= instr_cnt_r + CNT_W'(1);
         else
            instr_cnt_r <= instr_cnt_r;
      end
   end

   // Control decode from the registered state; only FETCH and BRANCH look at live inputs.
   always_comb begin
      pc_write_s  = 1'b0;
      ir_write_s  = 1'b0;
      reg_write_s = 1'b0;
      mem_read_s  = 1'b0;
      mem_write_s = 1'b0;
      IorD        = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSrc       = 2'b00;
      ALUOp       = '0;
      Fault       = 1'b0;
      case (state_r)
         FETCH: begin
            mem_read_s = 1'b1;
            ALUSrcB    = 2'b01;
            ALUOp      = ALU_ADD;
            ir_write_s = MemReady;
            pc_write_s = MemReady;
         end
         DECODE: begin
            ALUSrcB = 2'b11;
            ALUOp   = ALU_ADD;
         end
         EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_W'(funct_s);
         end
         WB_R: begin
            RegDst      = 1'b1;
            reg_write_s = 1'b1;
         end
         MEMADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUOp   = ALU_ADD;
         end
         MEM_RD: begin
            mem_read_s = 1'b1;
            IorD       = 1'b1;
         end
         MEM_WR: begin
            mem_write_s = 1'b1;
            IorD        = 1'b1;
         end
         WB_LD: begin
            MemtoReg    = 1'b1;
            reg_write_s = 1'b1;
         end
         BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUOp      = ALU_SUB;
            PCSrc      = 2'b01;
            pc_write_s = Zero;
         end
         JUMP: begin
            PCSrc      = 2'b10;
            pc_write_s = 1'b1;
         end
         FAULT:   Fault = 1'b1;
         default: Fault = 1'b1;
      endcase
   end

   // Write/read strobes are killed immediately while reset is held, even mid-access.
   assign PCWrite    = pc_write_s  & Rst;
   assign IRWrite    = ir_write_s  & Rst;
   assign RegWrite   = reg_write_s & Rst;
   assign MemRead    = mem_read_s  & Rst;
   assign MemWrite   = mem_write_s & Rst;
   assign State      = state_r;
   assign InstrCount = instr_cnt_r;

endmodule
